reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_sb_scoreboard.sv | 62 ++++++
 rtl/reg_file_sb.sv | 128 ++++++++++++
 tb/tb_reg_file_sb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-register scoreboard: one bit per register plus a registered population count.
module reg_file_sb_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_vld,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr_a,
    input  logic [ADDR_W-1:0]    clr_a_addr,
    input  logic                 clr_b,
    input  logic [ADDR_W-1:0]    clr_b_addr,
    output logic [2**ADDR_W-1:0] pend,
    output logic [ADDR_W:0]      pend_cnt
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0] set_dec_s;
    logic [NREGS-1:0] clr_dec_s;
    logic [NREGS-1:0] pend_nxt_s;
    logic [ADDR_W:0]  cnt_nxt_s;

    // Decode set/clear; a set names a newer producer so it overrides a same-cycle clear.
    always_comb begin
        set_dec_s = {NREGS{1'b0}};
        clr_dec_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            if (set_vld && (set_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                set_dec_s[i] = 1'b1;
            end else begin
                set_dec_s[i] = 1'b0;
            end
            clr_dec_s[i] = (clr_a && (clr_a_addr == ADDR_W'(i))) ||
                           (clr_b && (clr_b_addr == ADDR_W'(i)));
        end
        pend_nxt_s = set_dec_s | (pend & ~clr_dec_s);
    end

    // Population count of the next pend vector so the count lands together with it.
    always_comb begin
        cnt_nxt_s = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt_s = cnt_nxt_s + (ADDR_W+1)'(pend_nxt_s[i]);
        end
    end

    // Pend vector and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= {NREGS{1'b0}};
            pend_cnt <= {(ADDR_W+1){1'b0}};
        end else begin
            pend     <= pend_nxt_s;
            pend_cnt <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Dual-write, dual-read register file with write forwarding, conflict flag and pending scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic              iss_vld,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              wr_conflict
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  pend_s;
    logic              wr_a_s;
    logic              wr_b_s;
    logic              conflict_s;
    logic              conflict_r;
    logic              hit_a1_s, hit_b1_s, hit_a2_s, hit_b2_s;
    logic              zero1_s, zero2_s;

    // Writes that actually land; register 0 is immune when it is hardwired.
    assign wr_a_s     = we_a && !((ZERO_REG != 0) && (wa_a == {ADDR_W{1'b0}}));
    assign wr_b_s     = we_b && !((ZERO_REG != 0) && (wa_b == {ADDR_W{1'b0}}));
    assign conflict_s = wr_a_s && wr_b_s && (wa_a == wa_b);

    assign hit_a1_s = (BYPASS != 0) && wr_a_s && (wa_a == ra1);
    assign hit_b1_s = (BYPASS != 0) && wr_b_s && (wa_b == ra1);
    assign hit_a2_s = (BYPASS != 0) && wr_a_s && (wa_a == ra2);
    assign hit_b2_s = (BYPASS != 0) && wr_b_s && (wa_b == ra2);
    assign zero1_s  = (ZERO_REG != 0) && (ra1 == {ADDR_W{1'b0}});
    assign zero2_s  = (ZERO_REG != 0) && (ra2 == {ADDR_W{1'b0}});

    // Register array; B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_a_s) begin
                regs_r[wa_a] <= wd_a;
            end
            if (wr_b_s) begin
                regs_r[wa_b] <= wd_b;
            end
        end
    end

    // Conflict flag covers exactly the cycle after the colliding writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_r <= 1'b0;
        end else begin
            conflict_r <= conflict_s;
        end
    end

    assign wr_conflict = conflict_r;

    // Read port 1: reset forces zero, then hardwired zero, then forwarding (B over A), then storage.
    always_comb begin
        rd1 = {DATA_W{1'b0}};
        if (!rst_n || zero1_s) begin
            rd1 = {DATA_W{1'b0}};
        end else if (hit_b1_s) begin
            rd1 = wd_b;
        end else if (hit_a1_s) begin
            rd1 = wd_a;
        end else begin
            rd1 = regs_r[ra1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = {DATA_W{1'b0}};
        if (!rst_n || zero2_s) begin
            rd2 = {DATA_W{1'b0}};
        end else if (hit_b2_s) begin
            rd2 = wd_b;
        end else if (hit_a2_s) begin
            rd2 = wd_a;
        end else begin
            rd2 = regs_r[ra2];
        end
    end

    // A register being written this cycle is already resolved when it is forwarded.
    assign busy1 = rst_n && pend_s[ra1] && !(hit_a1_s || hit_b1_s);
    assign busy2 = rst_n && pend_s[ra2] && !(hit_a2_s || hit_b2_s);

    reg_file_sb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_vld    (iss_vld),
        .set_addr   (iss_addr),
        .clr_a      (we_a),
        .clr_a_addr (wa_a),
        .clr_b      (we_b),
        .clr_b_addr (wa_b),
        .pend       (pend_s),
        .pend_cnt   (pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int NREGS = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    addr_t      ra1, ra2, wa_a, wa_b, iss_addr;
    data_t      rd1, rd2, wd_a, wd_b;
    logic       we_a, we_b, iss_vld, busy1, busy2, wr_conflict;
    logic [5:0] pend_cnt;

    data_t m_regs [NREGS];
    bit    m_pend [NREGS];
    bit    m_conf;
    int    n_checks = 0;
    int    n_fail   = 0;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .iss_vld(iss_vld), .iss_addr(iss_addr), .busy1(busy1), .busy2(busy2),
        .pend_cnt(pend_cnt), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    function automatic data_t exp_rd(addr_t ra);
        if (rst_n !== 1'b1 || ra == '0) return '0;
        if (we_b && wa_b == ra) return wd_b;
        if (we_a && wa_a == ra) return wd_a;
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(addr_t ra);
        if (rst_n !== 1'b1) return 1'b0;
        if ((we_a && wa_a == ra) || (we_b && wa_b == ra)) return 1'b0;
        return m_pend[ra];
    endfunction

    function automatic logic [5:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_pend[i]);
        return 6'(c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; iss_vld = 1'b0;
        wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; iss_addr = '0;
    endtask

    // Clock edge: apply the architectural rules to the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            m_conf = we_a && we_b && (wa_a == wa_b) && (wa_a != '0);
            if (we_a && wa_a != '0) m_regs[wa_a] = wd_a;
            if (we_b && wa_b != '0) m_regs[wa_b] = wd_b;
            if (we_a) m_pend[wa_a] = 1'b0;
            if (we_b) m_pend[wa_b] = 1'b0;
            if (iss_vld && iss_addr != '0) m_pend[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); ra1 = '0; ra2 = '0;
        model_reset();
        #2 rst_n = 1'b0;
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1234_5678; iss_vld = 1'b1; iss_addr = 5'd3;
        ra1 = 5'd5; ra2 = 5'd3;
        #1;
        n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h want 0", rd1); end
        n_checks++; if (busy2 !== 1'b0 || pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt: got %b/%0d want 0/0", busy2, pend_cnt); end
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", wr_conflict); end
        tick();
        @(negedge clk);
        rst_n = 1'b1; idle();
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'hA5A5_5A5A;
        #3;
        n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_write_dropped: got %h want 0", rd1); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_issue_dropped: got %b want 0", busy2); end
        tick();
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt_after: got %0d want 0", pend_cnt); end
        @(negedge clk);
        idle(); ra1 = 5'd9;
        #3;
        n_checks++; if (rd1 !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL first_write: got %h want a5a55a5a", rd1); end
        tick();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle(); we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd9;
        #3;
        n_checks++; if (rd1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rd1: got %h want deadbeef", rd1); end
        n_checks++; if (rd2 !== exp_rd(ra2)) begin n_fail++; $display("FAIL other_rd2: got %h want %h", rd2, exp_rd(ra2)); end
        tick();
        @(negedge clk);
        idle();
        #3;
        n_checks++; if (rd1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stored_rd1: got %h want deadbeef", rd1); end
        tick();
    endtask

    task automatic test_conflict();
        @(negedge clk);
        idle(); we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11; we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h22; ra2 = 5'd7;
        #3;
        n_checks++; if (rd2 !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass: got %h want 22", rd2); end
        tick();
        n_checks++; if (wr_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_flag: got %b want 1", wr_conflict); end
        @(negedge clk);
        idle(); ra1 = 5'd7;
        #3;
        n_checks++; if (rd1 !== 32'h22) begin n_fail++; $display("FAIL conflict_winner: got %h want 22", rd1); end
        tick();
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_clear: got %b want 0", wr_conflict); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle(); we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF; we_b = 1'b1; wa_b = 5'd0; wd_b = 32'h1234;
        iss_vld = 1'b1; iss_addr = 5'd0; ra1 = 5'd0;
        #3;
        n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h want 0", rd1); end
        tick();
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL zero_conflict: got %b want 0", wr_conflict); end
        n_checks++; if (pend_cnt !== exp_cnt()) begin n_fail++; $display("FAIL zero_issue: got %0d want %0d", pend_cnt, exp_cnt()); end
        @(negedge clk);
        idle(); ra1 = 5'd0;
        #3;
        n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_stored: got %h want 0", rd1); end
        tick();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle(); iss_vld = 1'b1; iss_addr = 5'd3; ra1 = 5'd3;
        tick();
        n_checks++; if (busy1 !== 1'b1 || pend_cnt !== 6'd1) begin n_fail++; $display("FAIL issue_r3: got busy %b cnt %0d want 1/1", busy1, pend_cnt); end
        @(negedge clk);
        idle(); we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h33;
        #3;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_bypass: got %b want 0", busy1); end
        tick();
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL clear_r3: got %0d want 0", pend_cnt); end
        @(negedge clk);
        idle(); iss_vld = 1'b1; iss_addr = 5'd4; we_b = 1'b1; wa_b = 5'd4; wd_b = 32'h44; ra2 = 5'd4;
        tick();
        @(negedge clk);
        idle(); ra2 = 5'd4;
        #3;
        n_checks++; if (busy2 !== 1'b1 || pend_cnt !== 6'd1) begin n_fail++; $display("FAIL set_wins: got busy %b cnt %0d want 1/1", busy2, pend_cnt); end
        iss_vld = 1'b1; iss_addr = 5'd4;
        tick();
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL reissue: got %0d want 1", pend_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we_a = 1'($urandom_range(0, 1)); wa_a = 5'($urandom_range(0, 31)); wd_a = $urandom;
            we_b = 1'($urandom_range(0, 1)); wd_b = $urandom;
            wa_b = ($urandom_range(0, 3) == 0) ? wa_a : 5'($urandom_range(0, 31));
            iss_vld = 1'($urandom_range(0, 1)); iss_addr = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa_a : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? wa_b : 5'($urandom_range(0, 31));
            #3;
            n_checks++; if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2)) begin
                n_fail++; $display("FAIL rand_rd: got %h/%h want %h/%h", rd1, rd2, exp_rd(ra1), exp_rd(ra2));
            end
            n_checks++; if (busy1 !== exp_busy(ra1) || busy2 !== exp_busy(ra2)) begin
                n_fail++; $display("FAIL rand_busy: got %b/%b want %b/%b", busy1, busy2, exp_busy(ra1), exp_busy(ra2));
            end
            tick();
            n_checks++; if (pend_cnt !== exp_cnt() || wr_conflict !== m_conf) begin
                n_fail++; $display("FAIL rand_state: got cnt %0d conf %b want %0d/%b", pend_cnt, wr_conflict, exp_cnt(), m_conf);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < NREGS; i++) begin
            @(negedge clk);
            idle(); iss_vld = 1'b1; iss_addr = 5'(i);
            tick();
        end
        n_checks++; if (pend_cnt !== 6'd31) begin n_fail++; $display("FAIL fill_cnt: got %0d want 31", pend_cnt); end
        @(negedge clk);
        idle(); we_b = 1'b1; wa_b = 5'd6; wd_b = 32'h6666; ra1 = 5'd5; ra2 = 5'd6;
        #1;
        n_checks++; if (rd1 !== m_regs[5] || rd2 !== 32'h6666) begin n_fail++; $display("FAIL pre_reset_rd: got %h/%h want %h/6666", rd1, rd2, m_regs[5]); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (pend_cnt !== 6'd0 || wr_conflict !== 1'b0) begin n_fail++; $display("FAIL async_cnt: got %0d/%b want 0/0", pend_cnt, wr_conflict); end
        n_checks++; if (rd1 !== 32'h0 || rd2 !== 32'h0) begin n_fail++; $display("FAIL async_rd: got %h/%h want 0/0", rd1, rd2); end
        n_checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b/%b want 0/0", busy1, busy2); end
        tick();
        @(negedge clk);
        rst_n = 1'b1; idle(); ra1 = 5'd5; ra2 = 5'd7;
        #3;
        n_checks++; if (rd1 !== 32'h0 || rd2 !== 32'h0) begin n_fail++; $display("FAIL cleared_regs: got %h/%h want 0/0", rd1, rd2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
